// File: rtl/reset_sequencer_if.sv
// Request/acknowledge and staged reset bundle between the reset sequencer and
// the requesters and subsystems around it.
interface reset_sequencer_if #(
   parameter int N_REQ   = 3,
   parameter int N_STAGE = 4
);
   localparam int CAUSE_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]   req_i;
   logic               req_ack_o;
   logic [CAUSE_W-1:0] cause_o;
   logic [N_STAGE-1:0] stage_rst_o;
   logic [N_STAGE-1:0] clk_en_o;
   logic               busy_o;
   logic               done_o;
   logic [7:0]         seq_count_o;

   modport master (
      input  req_i,
      output req_ack_o, cause_o, stage_rst_o, clk_en_o, busy_o, done_o, seq_count_o
   );

   modport slave (
      output req_i,
      input  req_ack_o, cause_o, stage_rst_o, clk_en_o, busy_o, done_o, seq_count_o
   );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset/clock-enable sequencer for the 40 MHz domain: holds every stage in
// reset, starts clocks, then releases stages one by one before entering RUN.
module reset_sequencer #(
   parameter int N_REQ       = 3,
   parameter int N_STAGE     = 4,
   parameter int HOLD_CYCLES = 16,
   parameter int STAGE_GAP   = 8
) (
   input  logic               clk40MHz_i,
   input  logic               rst_i,
   reset_sequencer_if.master  bus
);
   localparam int CAUSE_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IDX_W   = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
   localparam int CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_ASSERT  = 2'd0,
      S_CLKON   = 2'd1,
      S_RELEASE = 2'd2,
      S_RUN     = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               accept_s;
   logic [CAUSE_W-1:0] win_s;

   logic               req_ack_q, req_ack_d;
   logic [CAUSE_W-1:0] cause_q, cause_d;
   logic [N_STAGE-1:0] stage_rst_q, stage_rst_d;
   logic [N_STAGE-1:0] clk_en_q, clk_en_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [7:0]         seq_count_q, seq_count_d;

   // Lowest set index wins; scanning from the top lets lower indices overwrite.
   function automatic logic [CAUSE_W-1:0] lowest_idx(input logic [N_REQ-1:0] v);
      logic [CAUSE_W-1:0] r;
      r = {CAUSE_W{1'b0}};
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            r = CAUSE_W'(i);
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // State and output registers.
   always_ff @(posedge clk40MHz_i) begin
      if (rst_i) begin
         state_q     <= S_ASSERT;
         cnt_q       <= {CNT_W{1'b0}};
         idx_q       <= {IDX_W{1'b0}};
         req_ack_q   <= 1'b0;
         cause_q     <= {CAUSE_W{1'b0}};
         stage_rst_q <= {N_STAGE{1'b1}};
         clk_en_q    <= {N_STAGE{1'b0}};
         busy_q      <= 1'b1;
         done_q      <= 1'b0;
         seq_count_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         req_ack_q   <= req_ack_d;
         cause_q     <= cause_d;
         stage_rst_q <= stage_rst_d;
         clk_en_q    <= clk_en_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         seq_count_q <= seq_count_d;
      end
   end

   // Next-state, phase counter and stage index.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      accept_s = 1'b0;
      win_s    = lowest_idx(bus.req_i);
      case (state_q)
         S_ASSERT: begin
            if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
               state_d = S_CLKON;
               cnt_d   = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_CLKON: begin
            if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               state_d = S_RELEASE;
               cnt_d   = {CNT_W{1'b0}};
               idx_d   = {IDX_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RELEASE: begin
            // The last stage gets a single cycle before RUN rather than a full gap.
            if (idx_q == IDX_W'(N_STAGE - 1)) begin
               state_d = S_RUN;
               cnt_d   = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_W'(STAGE_GAP - 1)) begin
               idx_d = idx_q + IDX_W'(1);
               cnt_d = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (|bus.req_i) begin
               accept_s = 1'b1;
               state_d  = S_ASSERT;
               cnt_d    = {CNT_W{1'b0}};
               idx_d    = {IDX_W{1'b0}};
            end else begin
               state_d = S_RUN;
            end
         end
         default: begin
            state_d = S_ASSERT;
            cnt_d   = {CNT_W{1'b0}};
            idx_d   = {IDX_W{1'b0}};
         end
      endcase
   end

   // Output values derived from the upcoming state so outputs stay registered.
   always_comb begin
      stage_rst_d = {N_STAGE{1'b1}};
      clk_en_d    = {N_STAGE{1'b1}};
      case (state_d)
         S_ASSERT: begin
            stage_rst_d = {N_STAGE{1'b1}};
            clk_en_d    = {N_STAGE{1'b0}};
         end
         S_CLKON: begin
            stage_rst_d = {N_STAGE{1'b1}};
            clk_en_d    = {N_STAGE{1'b1}};
         end
         S_RELEASE: begin
            for (int j = 0; j < N_STAGE; j++) begin
               if (IDX_W'(j) > idx_d) begin
                  stage_rst_d[j] = 1'b1;
               end else begin
                  stage_rst_d[j] = 1'b0;
               end
            end
            clk_en_d = {N_STAGE{1'b1}};
         end
         S_RUN: begin
            stage_rst_d = {N_STAGE{1'b0}};
            clk_en_d    = {N_STAGE{1'b1}};
         end
         default: begin
            stage_rst_d = {N_STAGE{1'b1}};
            clk_en_d    = {N_STAGE{1'b0}};
         end
      endcase

      busy_d    = (state_d != S_RUN);
      done_d    = (state_d == S_RUN) && (state_q != S_RUN);
      req_ack_d = accept_s;

      if (accept_s) begin
         cause_d = win_s;
         if (seq_count_q == 8'hFF) begin
            seq_count_d = seq_count_q;
         end else begin
            seq_count_d = seq_count_q + 8'd1;
         end
      end else begin
         cause_d     = cause_q;
         seq_count_d = seq_count_q;
      end
   end

   assign bus.req_ack_o   = req_ack_q;
   assign bus.cause_o     = cause_q;
   assign bus.stage_rst_o = stage_rst_q;
   assign bus.clk_en_o    = clk_en_q;
   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.seq_count_o = seq_count_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: checks staged timing every cycle and
// scores accepted requests (cause and count) against a queue of expectations.
module tb_reset_sequencer;
   localparam int HOLD = 16;
   localparam int GAP  = 8;
   localparam int NST  = 4;
   localparam int LAT  = HOLD + GAP * NST + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   logic [1:0] exp_cause = 2'd0;
   logic [7:0] exp_count = 8'd0;
   logic [7:0] sb_count  = 8'd0;
   logic [9:0] sb_q[$];
   logic [9:0] popped;

   reset_sequencer_if #(.N_REQ(3), .N_STAGE(NST)) bus ();

   reset_sequencer #(
      .N_REQ(3), .N_STAGE(NST), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP)
   ) dut (
      .clk40MHz_i(clk),
      .rst_i     (rst),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [1:0] c);
      if (sb_count != 8'hFF) sb_count = sb_count + 8'd1;
      sb_q.push_back({c, sb_count});
   endtask

   // Every acknowledge must match the oldest queued expectation.
   always @(negedge clk) begin
      if (bus.req_ack_o === 1'b1) begin
         total++;
         assert (sb_q.size() != 0) else begin
            bad++;
            $error("FAIL ack_unexpected observed=1 expected=0");
         end
         if (sb_q.size() != 0) begin
            popped = sb_q.pop_front();
            total++;
            assert ({bus.cause_o, bus.seq_count_o} === popped) else begin
               bad++;
               $error("FAIL ack_payload observed=%0h expected=%0h",
                      {bus.cause_o, bus.seq_count_o}, popped);
            end
         end
      end
   end

   // Called at the negedge showing cycle 0 of a sequence; returns at cycle last_s.
   task automatic run_seq(input string tag, input int last_s, input int p_start,
                          input int p_len, input logic [2:0] p_val);
      logic [3:0] e_stg;
      logic [3:0] e_clk;
      for (int s = 0; s <= last_s; s++) begin
         if (p_len > 0 && s == p_start) bus.req_i = p_val;
         if (p_len > 0 && s == p_start + p_len) bus.req_i = 3'b000;
         for (int j = 0; j < NST; j++) e_stg[j] = (s < HOLD + GAP * (j + 1));
         e_clk = (s >= HOLD) ? 4'hF : 4'h0;
         chk($sformatf("%s@%0d", tag, s),
             {12'd0, bus.stage_rst_o, bus.clk_en_o, bus.busy_o, bus.done_o,
              bus.cause_o, bus.seq_count_o},
             {12'd0, e_stg, e_clk, (s < LAT), (s == LAT), exp_cause, exp_count});
         if (s < last_s) @(negedge clk);
      end
   endtask

   initial begin
      bus.req_i = 3'b000;
      repeat (5) @(negedge clk);
      chk("reset_state",
          {bus.stage_rst_o, bus.clk_en_o, bus.busy_o, bus.done_o, bus.req_ack_o,
           bus.cause_o, bus.seq_count_o},
          {4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
      rst = 1'b0;
      run_seq("powerup", LAT, 0, 0, 3'b000);

      // Single request in the first RUN cycle, then a pulse ignored during RELEASE.
      bus.req_i = 3'b100;
      push(2'd2);
      @(negedge clk);
      chk("single_ack", {bus.req_ack_o, bus.stage_rst_o, bus.clk_en_o, bus.busy_o},
          {1'b1, 4'hF, 4'h0, 1'b1});
      bus.req_i = 3'b000;
      exp_cause = 2'd2;
      exp_count = sb_count;
      run_seq("single", LAT, 30, 3, 3'b001);

      // Two simultaneous requests: lowest index first, the other on the next window.
      bus.req_i = 3'b110;
      push(2'd1);
      push(2'd2);
      @(negedge clk);
      bus.req_i = 3'b100;
      exp_cause = 2'd1;
      exp_count = 8'd2;
      run_seq("prio", LAT, 0, 0, 3'b000);
      @(negedge clk);
      chk("prio2_ack", {bus.req_ack_o, bus.done_o}, {1'b1, 1'b0});
      bus.req_i = 3'b000;
      exp_cause = 2'd2;
      exp_count = 8'd3;
      run_seq("prio2", 35, 0, 0, 3'b000);

      // Mid-sequence reset at cycle 35.
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_state",
          {bus.stage_rst_o, bus.clk_en_o, bus.busy_o, bus.done_o, bus.req_ack_o,
           bus.cause_o, bus.seq_count_o},
          {4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0});
      rst = 1'b0;
      exp_cause = 2'd0;
      exp_count = 8'd0;
      sb_count  = 8'd0;
      run_seq("restart", LAT, 0, 0, 3'b000);

      // 256 accepted requests: the counter must saturate at 255.
      for (int i = 0; i < 256; i++) begin
         bus.req_i = 3'b001;
         push(2'd0);
         @(negedge clk);
         bus.req_i = 3'b000;
         repeat (LAT) @(negedge clk);
         chk($sformatf("sat_done_%0d", i), {bus.done_o, bus.cause_o, bus.seq_count_o},
             {1'b1, 2'd0, sb_count});
      end
      chk("sat_final", {24'd0, bus.seq_count_o}, 32'd255);
      repeat (3) @(negedge clk);
      chk("sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
